// File: rtl/mem_access_stage.sv
// mem_access_stage: MIPS MEM stage with word-only data port; sub-word stores use read-modify-write, big-endian lanes.
module mem_access_stage #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int REG_AW     = 5
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  ex_valid,
  input  logic [ADDR_WIDTH-1:0] ex_alu_result,
  input  logic [DATA_WIDTH-1:0] ex_rt_data,
  input  logic [REG_AW-1:0]     ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic [1:0]            ex_mem_size,
  input  logic                  ex_load_unsigned,
  output logic                  mem_stall,
  output logic                  dmem_req,
  output logic                  dmem_wren,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_busy,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  input  logic                  dmem_rvalid,
  output logic                  wb_valid,
  output logic                  wb_reg_write,
  output logic [REG_AW-1:0]     wb_rd,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  misalign
);
  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_t;
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [15:0] rt_q;
  logic [REG_AW-1:0] rd_q;
  logic [1:0] size_q;
  logic rw_q, st_q, uns_q;
  logic [DATA_WIDTH-1:0] wdata_q, load_val, merged, wb_d;
  logic [REG_AW-1:0] wb_rd_d;
  logic wb_rw_d, wb_fire, ex_mem, ex_mis, accept;
  logic [4:0] byte_sh, half_sh;
  logic [7:0] rbyte;
  logic [15:0] rhalf;
  assign accept    = ex_valid && state == IDLE;
  assign ex_mem    = ex_mem_read | ex_mem_write;
  assign ex_mis    = ex_mem & ((ex_mem_size[1] & |ex_alu_result[1:0]) |
                               (ex_mem_size == 2'b01 & ex_alu_result[0]));
  assign mem_stall = state != IDLE;
  assign dmem_req  = state == RD_REQ || state == WR_REQ;
  assign dmem_wren = state == WR_REQ;
  assign dmem_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign dmem_wdata = wdata_q;
  // Offset 0 is the most significant lane, hence the inverted offset bits.
  always_comb begin
    byte_sh  = {~addr_q[1:0], 3'b000};
    half_sh  = {~addr_q[1], 4'b0000};
    rbyte    = dmem_rdata[byte_sh +: 8];
    rhalf    = dmem_rdata[half_sh +: 16];
    load_val = size_q[1] ? dmem_rdata :
               size_q[0] ? {{16{~uns_q & rhalf[15]}}, rhalf} :
                           {{24{~uns_q & rbyte[7]}}, rbyte};
    merged   = dmem_rdata;
    if (size_q[0]) merged[half_sh +: 16] = rt_q;
    else           merged[byte_sh +: 8]  = rt_q[7:0];
  end
  always_comb begin
    state_nx = state;
    wb_fire  = 1'b0;
    wb_d     = wb_data;
    wb_rd_d  = wb_rd;
    wb_rw_d  = wb_reg_write;
    case (state)
      IDLE: if (ex_valid) begin
        if (ex_mis | ~ex_mem) begin
          wb_fire = 1'b1;
          wb_d    = ex_alu_result;
          wb_rd_d = ex_rd;
          wb_rw_d = ex_reg_write & ~ex_mem;
        end else begin
          state_nx = (ex_mem_read | ~ex_mem_size[1]) ? RD_REQ : WR_REQ;
        end
      end
      RD_REQ: state_nx = dmem_busy ? RD_REQ : RD_WAIT;
      RD_WAIT: if (dmem_rvalid) begin
        state_nx = st_q ? WR_REQ : IDLE;
        wb_fire  = ~st_q;
        wb_d     = st_q ? wb_data : load_val;
        wb_rd_d  = st_q ? wb_rd : rd_q;
        wb_rw_d  = st_q ? wb_reg_write : rw_q;
      end
      WR_REQ: if (!dmem_busy) begin
        state_nx = IDLE;
        wb_fire  = 1'b1;
        wb_rd_d  = rd_q;
        wb_rw_d  = 1'b0;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      addr_q       <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      size_q       <= '0;
      rw_q         <= 1'b0;
      st_q         <= 1'b0;
      uns_q        <= 1'b0;
      wdata_q      <= '0;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      misalign     <= 1'b0;
    end else begin
      state        <= state_nx;
      wb_valid     <= wb_fire;
      misalign     <= accept & ex_mis;
      wb_data      <= wb_d;
      wb_rd        <= wb_rd_d;
      wb_reg_write <= wb_rw_d;
      if (accept) begin
        addr_q  <= ex_alu_result;
        rt_q    <= ex_rt_data[15:0];
        rd_q    <= ex_rd;
        size_q  <= ex_mem_size;
        rw_q    <= ex_reg_write;
        st_q    <= ex_mem_write & ~ex_mem_read;
        uns_q   <= ex_load_unsigned;
        wdata_q <= ex_rt_data;
      end else if (state == RD_WAIT && dmem_rvalid && st_q) begin
        wdata_q <= merged;
      end
    end
  end
endmodule
